// File: rtl/dac_pkg.sv
// Shared definitions for the DAC serial transmitter: the FSM encoding, the
// DAC word width and the default rate parameters.
package dac_pkg;
  localparam int DAC_W             = 16;
  localparam int DEF_SCLK_DIV      = 4;
  localparam int DEF_SAMPLE_PERIOD = 200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample input and DAC serial bus bundle. The waveform side drives en/wave
// (master); the transmitter drives the serial pins and status (slave).
interface dac_spi_tx_if;
  import dac_pkg::*;

  logic             en;
  logic [DAC_W-1:0] wave;
  logic             dac_cs_n;
  logic             dac_sclk;
  logic             dac_mosi;
  logic             busy;
  logic             frame_done;

  modport master (
    output en, wave,
    input  dac_cs_n, dac_sclk, dac_mosi, busy, frame_done
  );

  modport slave (
    input  en, wave,
    output dac_cs_n, dac_sclk, dac_mosi, busy, frame_done
  );
endinterface

// File: rtl/sample_tick.sv
// Free-running period counter: counts 0..PERIOD-1 while enabled and flags
// the last count as a one-cycle tick. Disabling clears the count.
module sample_tick #(
  parameter int PERIOD = dac_pkg::DEF_SAMPLE_PERIOD
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);
  localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  if (PERIOD < 1) begin : g_bad_period
    $error("sample_tick: PERIOD must be at least 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: hold at zero while disabled, wrap after the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i)               cnt_d = '0;
    else if (cnt_q == LAST)  cnt_d = '0;
    else                     cnt_d = cnt_q + CW'(1);
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for a 16-bit DAC. Every sample tick captures the
// waveform word and shifts it out MSB first, then holds cs_n high for one
// SCLK half-period before the next frame may start. All outputs registered.
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int SCLK_DIV      = DEF_SCLK_DIV,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
  input logic         clk,
  input logic         rst_n,
  dac_spi_tx_if.slave bus
);
  localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);

  if (SCLK_DIV < 1 || SCLK_DIV > 255) begin : g_bad_div
    $error("dac_spi_tx: SCLK_DIV must be in 1..255");
  end
  if (SAMPLE_PERIOD < 33 * SCLK_DIV + 2) begin : g_bad_rate
    $error("dac_spi_tx: SAMPLE_PERIOD must be >= 33*SCLK_DIV+2");
  end

  logic             tick;
  state_t           state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [DAC_W-1:0] sh_q, sh_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // The MSB is presented on mosi at capture time; afterwards only the lower
  // bits feed the data line as they move up.
  logic unused_sh_msb;
  assign unused_sh_msb = sh_q[DAC_W-1];

  sample_tick #(.PERIOD(SAMPLE_PERIOD)) u_tick (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (bus.en),
    .tick_o (tick)
  );

  // Next-state and output logic; idle bus levels are the defaults.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    cs_n_d  = 1'b1;
    sclk_d  = 1'b0;
    mosi_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_SHIFT;
          sh_d    = bus.wave;
          div_d   = '0;
          bit_d   = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = bus.wave[DAC_W-1];
        end
      end
      ST_SHIFT: begin
        cs_n_d = 1'b0;
        busy_d = 1'b1;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: advance to the next bit, which the DAC samples
            // on the following rising edge.
            sclk_d = 1'b0;
            sh_d   = sh_q << 1;
            mosi_d = sh_q[DAC_W-2];
            bit_d  = bit_q + 5'd1;
            if (bit_q == 5'd15) begin
              state_d = ST_HOLD;
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_HOLD: begin
        busy_d = 1'b1;
        if (div_q == DIV_LAST) begin
          state_d = ST_IDLE;
          div_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.dac_cs_n   = cs_n_q;
  assign bus.dac_sclk   = sclk_q;
  assign bus.dac_mosi   = mosi_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: DUT a (SCLK_DIV=2, SAMPLE_PERIOD=80) covers data,
// capture, reset and enable behaviour; DUT b (SCLK_DIV=1, SAMPLE_PERIOD=35)
// covers the minimum legal frame rate. A monitor rebuilds each frame from
// the pins and checks it against the expected-word queues.
module tb_dac_spi_tx;
  logic clk = 1'b0;
  logic rst_a_n, rst_b_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  dac_spi_tx_if ifa ();
  dac_spi_tx_if ifb ();

  dac_spi_tx #(.SCLK_DIV(2), .SAMPLE_PERIOD(80)) dut_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .bus   (ifa)
  );

  dac_spi_tx #(.SCLK_DIV(1), .SAMPLE_PERIOD(35)) dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .bus   (ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        p_cs[2]   = '{1'b1, 1'b1};
  logic        p_sclk[2] = '{1'b0, 1'b0};
  logic        p_mosi[2] = '{1'b0, 1'b0};
  logic        p_fd[2]   = '{1'b0, 1'b0};
  bit          in_fr[2]  = '{1'b0, 1'b0};
  logic [15:0] word[2];
  int          last_fall[2] = '{-1, -1};
  int          rises[2]  = '{0, 0};
  int          lowc[2]   = '{0, 0};
  int          falls[2]  = '{0, 0};
  int          dones[2]  = '{0, 0};
  int          inv[2]    = '{0, 0};

  localparam logic [15:0] WB[10] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001, 16'hAAAA,
                                     16'h5555, 16'h1234, 16'hFEDC, 16'h7FFF, 16'hC3A5};

  function automatic int dv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic mon(input int i, input logic rn, input logic cs, input logic sc,
                     input logic mo, input logic bz, input logic fd);
    logic [15:0] e;
    int qs;
    if (rn) begin
      if (cs && (mo !== 1'b0 || sc !== 1'b0)) inv[i]++;
      if (!cs && bz !== 1'b1) inv[i]++;
      if (p_cs[i] && !cs) begin
        if (i == 1 && last_fall[1] >= 0)
          chk("b_fall_spacing", 32'(cyc - last_fall[1]), 32'd35);
        last_fall[i] = cyc;
        in_fr[i] = 1'b1;
        rises[i] = 0;
        lowc[i] = 0;
        word[i] = '0;
        falls[i]++;
      end
      if (!cs) lowc[i]++;
      if (!p_sclk[i] && sc) begin
        rises[i]++;
        word[i] = {word[i][14:0], mo};
        if (mo !== p_mosi[i]) inv[i]++;
      end
      if (fd) begin
        dones[i]++;
        if (p_fd[i]) inv[i]++;
        qs = (i == 0) ? q0.size() : q1.size();
        if (!in_fr[i] || qs == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame_done dut%0d: pulse at cycle %0d, expected none", i, cyc);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("frame_word%0d", i), 32'(word[i]), 32'(e));
          chk($sformatf("sclk_rises%0d", i), 32'(rises[i]), 32'd16);
          chk($sformatf("cs_low_cycles%0d", i), 32'(lowc[i]), 32'(32 * dv(i)));
          chk($sformatf("done_latency%0d", i), 32'(cyc - last_fall[i]), 32'(33 * dv(i)));
          chk($sformatf("busy_at_done%0d", i), {31'd0, bz}, 32'd0);
        end
        in_fr[i] = 1'b0;
      end
    end else begin
      in_fr[i] = 1'b0;
    end
    p_cs[i]   = cs;
    p_sclk[i] = sc;
    p_mosi[i] = mo;
    p_fd[i]   = fd;
  endtask

  always @(negedge clk) begin
    mon(0, rst_a_n, ifa.dac_cs_n, ifa.dac_sclk, ifa.dac_mosi, ifa.busy, ifa.frame_done);
    mon(1, rst_b_n, ifb.dac_cs_n, ifb.dac_sclk, ifb.dac_mosi, ifb.busy, ifb.frame_done);
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_fall(input int i, input int lim);
    int f0;
    int n;
    f0 = falls[i];
    n = 0;
    while (falls[i] == f0 && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (falls[i] == f0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_cs_fall dut%0d: no cs_n fall within %0d cycles", i, lim);
    end
  endtask

  task automatic wait_empty(input int i, input int lim);
    int n;
    n = 0;
    while (((i == 0) ? q0.size() : q1.size()) > 0 && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("queue_drained%0d", i), 32'((i == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int f0;
    int n;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    ifa.en = 1'b0;
    ifa.wave = '0;
    ifb.en = 1'b0;
    ifb.wave = '0;
    wait_cycles(3);
    chk("a_reset_state", {27'd0, ifa.dac_cs_n, ifa.dac_sclk, ifa.dac_mosi, ifa.busy, ifa.frame_done}, 32'b10000);
    chk("b_reset_state", {27'd0, ifb.dac_cs_n, ifb.dac_sclk, ifb.dac_mosi, ifb.busy, ifb.frame_done}, 32'b10000);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    wait_cycles(2);

    // Minimum-period back-to-back frames on DUT b
    ifb.wave = WB[0];
    q1.push_back(WB[0]);
    ifb.en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_fall(1, 40);
      if (k < 9) begin
        ifb.wave = WB[k+1];
        q1.push_back(WB[k+1]);
      end
    end
    wait_empty(1, 40);
    ifb.en = 1'b0;
    chk("b_frames_done", 32'(dones[1]), 32'd10);

    // Serial data and first-tick latency on DUT a
    ifa.wave = 16'hA5C3;
    q0.push_back(16'hA5C3);
    ifa.en = 1'b1;
    t0 = cyc;
    wait_fall(0, 100);
    chk("a_first_tick_latency", 32'(last_fall[0] - t0), 32'd80);

    // Capture stability: wave changes mid-frame
    ifa.wave = 16'h8000;
    q0.push_back(16'h8000);
    wait_fall(0, 100);
    wait_cycles(20);
    ifa.wave = 16'h0001;
    q0.push_back(16'h0001);
    wait_fall(0, 100);

    // Reset at the 8th sclk rise of a frame
    ifa.wave = 16'h5A5A;
    wait_fall(0, 100);
    n = 0;
    while (rises[0] < 8 && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("a_rise8_reached", 32'(rises[0]), 32'd8);
    rst_a_n = 1'b0;
    wait_cycles(1);
    chk("a_abort_outputs", {27'd0, ifa.dac_cs_n, ifa.dac_sclk, ifa.dac_mosi, ifa.busy, ifa.frame_done}, 32'b10000);
    wait_cycles(2);
    rst_a_n = 1'b1;
    t0 = cyc;
    q0.push_back(16'h5A5A);
    wait_fall(0, 100);
    chk("a_tick_after_reset", 32'(last_fall[0] - t0), 32'd80);

    // Enable dropped mid-frame
    wait_cycles(10);
    ifa.en = 1'b0;
    f0 = falls[0];
    wait_cycles(200);
    chk("a_no_fall_while_disabled", 32'(falls[0] - f0), 32'd0);
    chk("a_frame_completed_after_disable", 32'(q0.size()), 32'd0);
    ifa.wave = 16'hFFFF;
    q0.push_back(16'hFFFF);
    ifa.en = 1'b1;
    t0 = cyc;
    wait_fall(0, 100);
    chk("a_tick_after_enable", 32'(last_fall[0] - t0), 32'd80);
    wait_empty(0, 100);
    ifa.en = 1'b0;
    wait_cycles(5);

    chk("a_frames_done", 32'(dones[0]), 32'd5);
    chk("a_pin_invariants", 32'(inv[0]), 32'd0);
    chk("b_pin_invariants", 32'(inv[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 4: clk cycles per SCLK half-period, legal range 1..255.
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 200: clk cycles between frame starts, legal when >= 33*SCLK_DIV+2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: sample-tick enable.
REQ-006 SHALL have port wave, input, 16 bits: unsigned offset-binary sample from the waveform selector (mid-scale 16'd32768).
REQ-007 SHALL have port dac_cs_n, output, 1 bit: DAC chip select, active low.
REQ-008 SHALL have port dac_sclk, output, 1 bit: serial clock, idle low (SPI mode 0).
REQ-009 SHALL have port dac_mosi, output, 1 bit: serial data, MSB first.
REQ-010 SHALL have port busy, output, 1 bit: high whenever a frame is in progress.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-012 Period counter SHALL count 0..SAMPLE_PERIOD-1 and wrap while en=1; tick = counter at SAMPLE_PERIOD-1 with en=1.
REQ-013 en=0 SHALL clear the period counter and suppress ticks; a frame already in progress SHALL complete unaffected.
REQ-014 FSM states SHALL be IDLE, SHIFT and HOLD.
REQ-015 IDLE SHALL drive cs_n=1, sclk=0 and busy=0.
REQ-016 A tick in IDLE at cycle T SHALL capture wave into a 16-bit shift register and enter SHIFT at T+1 with cs_n=0, sclk=0, busy=1 and mosi=wave[15] as sampled at T.
REQ-017 In SHIFT a half-period counter SHALL toggle sclk every SCLK_DIV cycles: rising edges at T+1+(2k+1)*SCLK_DIV and falling edges at T+1+(2k+2)*SCLK_DIV, for k=0..15.
REQ-018 On each falling sclk edge the shift register SHALL shift left and a 5-bit bit counter SHALL increment; mosi SHALL be stable across every rising edge.
REQ-019 On the 16th falling edge, at T+1+32*SCLK_DIV, the FSM SHALL enter HOLD with cs_n=1, sclk=0 and busy=1.
REQ-020 HOLD SHALL last SCLK_DIV cycles, then the FSM SHALL return to IDLE at T+1+33*SCLK_DIV, with frame_done=1 for that single cycle and busy=0.
REQ-021 Changes on wave after capture SHALL NOT affect the current frame.
REQ-022 A tick arriving while not in IDLE SHALL be ignored; the parameter constraint in REQ-002 makes this unreachable in legal configurations.
REQ-023 mosi SHALL be 0 outside SHIFT.
REQ-024 All outputs SHALL be registered, with no combinational path from wave or en to any output.

Reset
REQ-025 rst_n=0 on a clk edge SHALL force IDLE, clear all counters and the shift register, and set cs_n=1, sclk=0, mosi=0, busy=0 and frame_done=0.
REQ-026 Reset mid-frame SHALL abort the frame immediately, with no frame_done pulse.
REQ-027 The first tick after reset release SHALL occur SAMPLE_PERIOD cycles after the first enabled cycle.

Structure
REQ-028 A shared package dac_pkg SHALL hold the FSM state encoding, the 16-bit DAC word width constant and the default SCLK_DIV and SAMPLE_PERIOD values.
REQ-029 The period counter and tick SHALL be a sub-module named sample_tick, reused by other rate-generation logic.
REQ-030 The implementation SHALL check the parameter constraints at elaboration.

Verification
REQ-031 Serial data: SCLK_DIV=2, SAMPLE_PERIOD=80, wave=16'hA5C3, en=1 -> one frame whose rising-edge samples read 1010_0101_1100_0011, 16 sclk rises, cs_n low for 64 cycles, frame_done at T+67.
REQ-032 Capture stability: wave changes from 16'h8000 to 16'h0001 mid-frame -> the frame shifts out 16'h8000 and the next frame shifts out 16'h0001.
REQ-033 Reset mid-frame: rst_n=0 at the 8th sclk rise -> the next cycle shows cs_n=1, sclk=0, busy=0, with no frame_done; after release, the next frame is complete and correct.
REQ-034 Enable: en deasserted mid-frame -> the frame completes; no further cs_n falls while en=0; after en=1 the first frame starts exactly SAMPLE_PERIOD cycles later.
REQ-035 Rate: SCLK_DIV=1, SAMPLE_PERIOD=35 (minimum legal), 10 frames -> cs_n falling edges exactly 35 cycles apart, with no dropped frames.
